// File: rtl/ysyx_23060236_dcache_ctrl_pkg.sv
// Shared widths, AXI response codes and controller state encoding for the dcache controller.
package ysyx_23060236_dcache_ctrl_pkg;

    localparam int ADDR_LEN   = 32;
    localparam int DATA_LEN   = 32;
    localparam int OFFSET_LEN = 2;
    localparam int INDEX_LEN  = 4;
    localparam int TAG_LEN    = ADDR_LEN - OFFSET_LEN - INDEX_LEN;
    localparam int STRB_LEN   = DATA_LEN / 8;

    localparam logic [ADDR_LEN-1:0] DEF_UC_BASE = 32'hA000_0000;
    localparam logic [ADDR_LEN-1:0] DEF_UC_MASK = 32'hF000_0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_MISS_R,
        S_FILL,
        S_RESP,
        S_WB_AW,
        S_WB_B,
        S_UC_AR,
        S_UC_R,
        S_UC_W,
        S_UC_B
    } state_t;

endpackage

// File: rtl/ysyx_23060236_dcache_ctrl_if.sv
// AXI memory-side bus of the dcache controller; master = controller, slave = memory.
interface ysyx_23060236_dcache_ctrl_if;
    import ysyx_23060236_dcache_ctrl_pkg::*;

    logic [ADDR_LEN-1:0] araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_LEN-1:0] rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_LEN-1:0] awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_LEN-1:0] wdata;
    logic [STRB_LEN-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ysyx_23060236_byte_merge.sv
// Combinational byte-lane merge: lanes with strb set take new_word, others keep old_word.
module ysyx_23060236_byte_merge
    import ysyx_23060236_dcache_ctrl_pkg::*;
(
    input  logic [DATA_LEN-1:0] old_word,
    input  logic [DATA_LEN-1:0] new_word,
    input  logic [STRB_LEN-1:0] strb,
    output logic [DATA_LEN-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < STRB_LEN; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/ysyx_23060236_dcache_ctrl.sv
// Write-back/write-allocate dcache controller with uncached bypass; dirty victims are
// written back after the fill and response, and no new request is taken until that finishes.
module ysyx_23060236_dcache_ctrl
    import ysyx_23060236_dcache_ctrl_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] UC_BASE = DEF_UC_BASE,
    parameter logic [ADDR_LEN-1:0] UC_MASK = DEF_UC_MASK
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    input  logic [STRB_LEN-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [ADDR_LEN-1:0] cache_araddr,
    output logic [ADDR_LEN-1:0] cache_awaddr,
    input  logic [DATA_LEN-1:0] cache_rdata,
    input  logic                cache_hit,
    output logic [DATA_LEN-1:0] cache_wdata,
    output logic                cache_wvalid,
    output logic                cache_dirty,
    input  logic                cache_wdt,
    input  logic [TAG_LEN-1:0]  cache_reptag,
    input  logic [DATA_LEN-1:0] cache_repdata,
    ysyx_23060236_dcache_ctrl_if.master axi
);

    state_t state, state_nxt;

    logic [ADDR_LEN-1:0] addr_q;
    logic                wen_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [STRB_LEN-1:0] wstrb_q;
    logic [DATA_LEN-1:0] line_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic                err_q;
    logic                victim_dirty;
    logic                aw_done;
    logic                w_done;

    logic                req_uc;
    logic                write_phase;
    logic                aw_fire, w_fire, aw_fin, w_fin;
    logic [DATA_LEN-1:0] merge_old;
    logic [STRB_LEN-1:0] merge_strb;
    logic [DATA_LEN-1:0] merge_out;

    assign req_uc      = (req_addr & UC_MASK) == UC_BASE;
    assign write_phase = (state == S_WB_AW) || (state == S_UC_W);
    assign aw_fire     = axi.awvalid && axi.awready;
    assign w_fire      = axi.wvalid && axi.wready;
    assign aw_fin      = aw_done || aw_fire;
    assign w_fin       = w_done || w_fire;

    // One merger serves both the store-hit (old = array word) and fill (old = refill line) paths.
    assign merge_old  = (state == S_FILL) ? line_q : cache_rdata;
    assign merge_strb = wen_q ? wstrb_q : '0;

    ysyx_23060236_byte_merge u_merge (
        .old_word (merge_old),
        .new_word (wdata_q),
        .strb     (merge_strb),
        .merged   (merge_out)
    );

    assign req_ready    = (state == S_IDLE);
    assign resp_valid   = (state == S_RESP);
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;

    assign cache_araddr = addr_q;
    assign cache_awaddr = addr_q;
    assign cache_wdata  = merge_out;
    assign cache_wvalid = ((state == S_LOOKUP) && cache_hit && wen_q) || (state == S_FILL);
    assign cache_dirty  = wen_q;

    assign axi.araddr  = addr_q;
    assign axi.arvalid = (state == S_MISS_AR) || (state == S_UC_AR);
    assign axi.rready  = (state == S_MISS_R) || (state == S_UC_R);
    // The victim tag/data were captured by the array on the fill edge and stay stable here.
    assign axi.awaddr  = (state == S_WB_AW)
                       ? {cache_reptag, addr_q[OFFSET_LEN +: INDEX_LEN], {OFFSET_LEN{1'b0}}}
                       : addr_q;
    assign axi.wdata   = (state == S_WB_AW) ? cache_repdata : wdata_q;
    assign axi.wstrb   = (state == S_WB_AW) ? '1 : wstrb_q;
    assign axi.awvalid = write_phase && !aw_done;
    assign axi.wvalid  = write_phase && !w_done;
    assign axi.bready  = (state == S_WB_B) || (state == S_UC_B);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (req_valid) state_nxt = req_uc ? (req_wen ? S_UC_W : S_UC_AR) : S_LOOKUP;
            S_LOOKUP:  state_nxt = cache_hit ? S_RESP : S_MISS_AR;
            S_MISS_AR: if (axi.arready) state_nxt = S_MISS_R;
            S_MISS_R:  if (axi.rvalid) state_nxt = (axi.rresp == RESP_OKAY) ? S_FILL : S_RESP;
            S_FILL:    state_nxt = S_RESP;
            S_RESP:    if (resp_ready) state_nxt = victim_dirty ? S_WB_AW : S_IDLE;
            S_WB_AW:   if (aw_fin && w_fin) state_nxt = S_WB_B;
            S_WB_B:    if (axi.bvalid) state_nxt = S_IDLE;
            S_UC_AR:   if (axi.arready) state_nxt = S_UC_R;
            S_UC_R:    if (axi.rvalid) state_nxt = S_RESP;
            S_UC_W:    if (aw_fin && w_fin) state_nxt = S_UC_B;
            S_UC_B:    if (axi.bvalid) state_nxt = S_RESP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            line_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            victim_dirty <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    addr_q       <= req_addr;
                    wen_q        <= req_wen;
                    wdata_q      <= req_wdata;
                    wstrb_q      <= req_wstrb;
                    err_q        <= 1'b0;
                    victim_dirty <= 1'b0;
                end
                S_LOOKUP: begin
                    if (!cache_hit)  victim_dirty <= cache_wdt;
                    else if (wen_q)  victim_dirty <= 1'b0;
                    else             rdata_q      <= cache_rdata;
                end
                S_MISS_R: if (axi.rvalid) begin
                    if (axi.rresp == RESP_OKAY) begin
                        line_q <= axi.rdata;
                    end else begin
                        // A failed refill leaves the array untouched, so the victim stays put.
                        err_q        <= 1'b1;
                        victim_dirty <= 1'b0;
                    end
                end
                S_FILL: rdata_q <= line_q;
                S_UC_R: if (axi.rvalid) begin
                    rdata_q <= axi.rdata;
                    err_q   <= (axi.rresp != RESP_OKAY);
                end
                S_UC_B: if (axi.bvalid) err_q <= (axi.bresp != RESP_OKAY);
                default: ;
            endcase

            if (write_phase) begin
                if (aw_fin && w_fin) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_dcache_ctrl.sv
// Scoreboard bench: directed requests push expected AR/AW/W/array-write/response items; monitors pop and compare.
module tb_ysyx_23060236_dcache_ctrl;
    import ysyx_23060236_dcache_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] cache_araddr, cache_awaddr, cache_rdata, cache_wdata, cache_repdata;
    logic        cache_hit, cache_wvalid, cache_dirty, cache_wdt;
    logic [25:0] cache_reptag;

    ysyx_23060236_dcache_ctrl_if axi();

    ysyx_23060236_dcache_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cache_araddr(cache_araddr), .cache_awaddr(cache_awaddr),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .cache_wdata(cache_wdata), .cache_wvalid(cache_wvalid), .cache_dirty(cache_dirty),
        .cache_wdt(cache_wdt), .cache_reptag(cache_reptag), .cache_repdata(cache_repdata),
        .axi(axi)
    );

    typedef struct { logic [31:0] data; logic err; logic chk; } resp_t;
    typedef struct { logic [3:0] idx; logic [31:0] data; logic dirty; } cw_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;

    resp_t       exp_resp[$];
    cw_t         exp_cw[$];
    w_t          exp_w[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];

    int n_cmp = 0;
    int n_err = 0;

    // AXI slave knobs
    logic [31:0] rd_val  = '0;
    logic [1:0]  rd_resp = 2'b00;
    logic [1:0]  wr_resp = 2'b00;
    int ar_stall = 0, r_stall = 0, aw_stall = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %h, required nothing", name, act);
    endtask

    // Array model: 16 lines, one word each, victim captured on every write.
    bit          arr_v[16];
    bit          arr_d[16];
    logic [25:0] arr_tag[16];
    logic [31:0] arr_dat[16];

    always_comb begin
        cache_hit   = arr_v[cache_araddr[5:2]] && (arr_tag[cache_araddr[5:2]] == cache_araddr[31:6]);
        cache_rdata = arr_dat[cache_araddr[5:2]];
        cache_wdt   = arr_v[cache_awaddr[5:2]] && arr_d[cache_awaddr[5:2]]
                      && (arr_tag[cache_awaddr[5:2]] != cache_awaddr[31:6]);
    end

    always @(posedge clock) begin
        if (cache_wvalid) begin
            cache_reptag                <= arr_tag[cache_awaddr[5:2]];
            cache_repdata               <= arr_dat[cache_awaddr[5:2]];
            arr_tag[cache_awaddr[5:2]]  <= cache_awaddr[31:6];
            arr_dat[cache_awaddr[5:2]]  <= cache_wdata;
            arr_v[cache_awaddr[5:2]]    <= 1'b1;
            arr_d[cache_awaddr[5:2]]    <= cache_dirty;
        end
    end

    // AR + R slave
    initial begin
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
        forever begin
            @(posedge clock); #1;
            if (axi.arvalid && !reset) begin
                bit aborted;
                aborted = 0;
                for (int i = 0; i < ar_stall; i++) begin
                    @(posedge clock); #1;
                    chk("ar_hold", axi.arvalid, 1);
                end
                axi.arready = 1;
                @(posedge clock); #1;
                axi.arready = 0;
                for (int i = 0; i < r_stall; i++) begin
                    @(negedge clock);
                    if (reset) aborted = 1;
                end
                if (r_stall > 0) begin @(posedge clock); #1; end
                if (!aborted) begin
                    axi.rvalid = 1; axi.rdata = rd_val; axi.rresp = rd_resp;
                    forever begin
                        @(negedge clock);
                        if (axi.rready || reset) break;
                    end
                    @(posedge clock); #1;
                    axi.rvalid = 0;
                end
            end
        end
    end

    // AW slave
    initial begin
        axi.awready = 0;
        forever begin
            @(posedge clock); #1;
            if (axi.awvalid && !reset) begin
                for (int i = 0; i < aw_stall; i++) begin
                    @(posedge clock); #1;
                    chk("aw_hold", axi.awvalid, 1);
                end
                axi.awready = 1;
                @(posedge clock); #1;
                axi.awready = 0;
                aw_cnt++;
            end
        end
    end

    // W slave
    initial begin
        axi.wready = 0;
        forever begin
            @(posedge clock); #1;
            if (axi.wvalid && !reset) begin
                axi.wready = 1;
                @(posedge clock); #1;
                axi.wready = 0;
                w_cnt++;
            end
        end
    end

    // B slave: one response per completed AW+W pair
    initial begin
        axi.bvalid = 0; axi.bresp = '0;
        forever begin
            @(posedge clock); #1;
            if (aw_cnt > b_cnt && w_cnt > b_cnt) begin
                axi.bvalid = 1; axi.bresp = wr_resp;
                forever begin
                    @(negedge clock);
                    if (axi.bready) break;
                end
                @(posedge clock); #1;
                axi.bvalid = 0;
                b_cnt++;
            end
        end
    end

    // Monitor: every observed handshake pops its expected item.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (axi.arvalid && axi.arready) begin
                    if (exp_ar.size() == 0) bad("ar_unexpected", axi.araddr);
                    else chk("ar_addr", axi.araddr, exp_ar.pop_front());
                end
                if (axi.awvalid && axi.awready) begin
                    if (exp_aw.size() == 0) bad("aw_unexpected", axi.awaddr);
                    else chk("aw_addr", axi.awaddr, exp_aw.pop_front());
                end
                if (axi.wvalid && axi.wready) begin
                    if (exp_w.size() == 0) bad("w_unexpected", axi.wdata);
                    else begin
                        w_t e;
                        e = exp_w.pop_front();
                        chk("w_data", axi.wdata, e.data);
                        chk("w_strb", axi.wstrb, e.strb);
                    end
                end
                if (cache_wvalid) begin
                    if (exp_cw.size() == 0) bad("cw_unexpected", cache_wdata);
                    else begin
                        cw_t e;
                        e = exp_cw.pop_front();
                        chk("cw_index", cache_awaddr[5:2], e.idx);
                        chk("cw_data", cache_wdata, e.data);
                        chk("cw_dirty", cache_dirty, e.dirty);
                    end
                end
                if (resp_valid && resp_ready) begin
                    if (exp_resp.size() == 0) bad("resp_unexpected", resp_rdata);
                    else begin
                        resp_t e;
                        e = exp_resp.pop_front();
                        if (e.chk) chk("resp_rdata", resp_rdata, e.data);
                        chk("resp_err", resp_err, e.err);
                    end
                end
            end
        end
    end

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        bit ok;
        ok = 0;
        @(posedge clock); #1;
        req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) bad("timeout_accept", addr);
        @(posedge clock); #1;
        req_valid = 0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (req_ready && exp_resp.size() == 0 && exp_ar.size() == 0 && exp_aw.size() == 0
                && exp_w.size() == 0 && exp_cw.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bad(name, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0;
        bit seen;
        req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("reset_state", {req_ready, resp_valid, resp_err, axi.arvalid, axi.rready,
                            axi.awvalid, axi.wvalid, axi.bready, cache_wvalid}, 9'b1_0000_0000);

        // Cold load miss, clean fill
        rd_val = 32'h1234_5678;
        exp_ar.push_back(32'h8000_0010);
        exp_cw.push_back(cw_t'{4'd4, 32'h1234_5678, 1'b0});
        exp_resp.push_back(resp_t'{32'h1234_5678, 1'b0, 1'b1});
        issue(0, 32'h8000_0010, 0, 0);
        wait_done("timeout_cold_load");

        // Load hit: LOOKUP one cycle after acceptance, RESP the next
        exp_resp.push_back(resp_t'{32'h1234_5678, 1'b0, 1'b1});
        issue(0, 32'h8000_0010, 0, 0);
        @(negedge clock); chk("hit_lat_n1", resp_valid, 0);
        @(negedge clock); chk("hit_lat_n2", resp_valid, 1);
        wait_done("timeout_load_hit");

        // Store hit byte 1
        exp_cw.push_back(cw_t'{4'd4, 32'h1234_AB78, 1'b1});
        exp_resp.push_back(resp_t'{32'h0, 1'b0, 1'b0});
        issue(1, 32'h8000_0010, 32'h0000_AB00, 4'b0010);
        wait_done("timeout_store_hit");

        // Conflict load evicts dirty 0x8000_0010
        rd_val = 32'hDEAD_BEEF;
        b0 = b_cnt;
        exp_ar.push_back(32'h8000_0050);
        exp_cw.push_back(cw_t'{4'd4, 32'hDEAD_BEEF, 1'b0});
        exp_resp.push_back(resp_t'{32'hDEAD_BEEF, 1'b0, 1'b1});
        exp_aw.push_back(32'h8000_0010);
        exp_w.push_back(w_t'{32'h1234_AB78, 4'hF});
        issue(0, 32'h8000_0050, 0, 0);
        wait_done("timeout_writeback");
        chk("ready_after_b", b_cnt, b0 + 1);

        // Uncached store with stalled AW and stalled response acceptance
        aw_stall = 5;
        resp_ready = 0;
        exp_aw.push_back(32'hA000_0004);
        exp_w.push_back(w_t'{32'h5566_0000, 4'b1100});
        exp_resp.push_back(resp_t'{32'h0, 1'b0, 1'b0});
        issue(1, 32'hA000_0004, 32'h5566_0000, 4'b1100);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (resp_valid) begin seen = 1; break; end
        end
        if (!seen) bad("timeout_uc_store_resp", 0);
        repeat (5) begin
            @(negedge clock);
            chk("resp_hold", resp_valid, 1);
        end
        @(posedge clock); #1;
        resp_ready = 1;
        wait_done("timeout_uc_store");
        aw_stall = 0;

        // Uncached load with stalled AR
        ar_stall = 5;
        rd_val = 32'hCAFE_F00D;
        exp_ar.push_back(32'hA000_0008);
        exp_resp.push_back(resp_t'{32'hCAFE_F00D, 1'b0, 1'b1});
        issue(0, 32'hA000_0008, 0, 0);
        wait_done("timeout_uc_load");
        ar_stall = 0;

        // Uncached store with bus error
        wr_resp = RESP_SLVERR;
        exp_aw.push_back(32'hA000_000C);
        exp_w.push_back(w_t'{32'h0102_0304, 4'hF});
        exp_resp.push_back(resp_t'{32'h0, 1'b1, 1'b0});
        issue(1, 32'hA000_000C, 32'h0102_0304, 4'hF);
        wait_done("timeout_uc_store_err");
        wr_resp = RESP_OKAY;

        // Store miss allocates a dirty line at index 8
        rd_val = 32'h1122_3344;
        exp_ar.push_back(32'h8000_0020);
        exp_cw.push_back(cw_t'{4'd8, 32'h1122_33EE, 1'b1});
        exp_resp.push_back(resp_t'{32'h0, 1'b0, 1'b0});
        issue(1, 32'h8000_0020, 32'h0000_00EE, 4'b0001);
        wait_done("timeout_store_miss");

        // Conflicting load whose refill errors: no fill, no write-back
        rd_resp = RESP_SLVERR;
        exp_ar.push_back(32'h8000_0060);
        exp_resp.push_back(resp_t'{32'h0, 1'b1, 1'b0});
        issue(0, 32'h8000_0060, 0, 0);
        wait_done("timeout_miss_err");
        repeat (5) @(negedge clock);
        rd_resp = RESP_OKAY;

        // Reset while waiting in MISS_R
        r_stall = 10;
        exp_ar.push_back(32'h8000_0070);
        issue(0, 32'h8000_0070, 0, 0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (axi.rready) begin seen = 1; break; end
        end
        if (!seen) bad("timeout_miss_r", 0);
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        chk("reset_mid_miss", {req_ready, resp_valid, axi.arvalid, axi.rready,
                               axi.awvalid, axi.wvalid, axi.bready, cache_wvalid}, 8'b1000_0000);
        repeat (15) @(negedge clock);
        r_stall = 0;

        // Recovery: dirty-free hit on the line filled before
        exp_resp.push_back(resp_t'{32'hDEAD_BEEF, 1'b0, 1'b1});
        issue(0, 32'h8000_0050, 0, 0);
        wait_done("timeout_recovery");

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
